// File: rtl/voice_cmd_tx.sv
// voice_cmd_tx
// ------------
// Transmit side of the voice-command UART link. A send request makes the
// block push the fixed command CMD (high byte first) into the shared UART
// byte transmitter, one byte per tx_start/tx_done handshake, with GAP_CYC
// idle cycles between bytes.
//
// Build option:
//   VOICE_CMD_CRLF_EN  when defined, 8'h0D and 8'h0A follow CMD[7:0]
//                      (4 bytes per command); when undefined, exactly 2.
//
// Handshake: the block pulses tx_start for one cycle with tx_data valid;
// the transmitter latches tx_data on that pulse and later pulses tx_done
// for one cycle when the byte is on the wire. tx_data is held until the
// next tx_start, so it is stable for the whole transfer. tx_done is only
// honoured in WAIT_DONE.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset (aborts any transfer)
//   send_req     request to send the command, sampled every cycle
//   tx_done      one-cycle pulse from the UART TX: current byte finished
//   tx_data      byte presented to the UART TX
//   tx_start     one-cycle pulse, UART TX latches tx_data
//   busy         high from request acceptance until return to IDLE
//   send_done    one-cycle pulse after the last byte's tx_done
//   err_timeout  one-cycle pulse (first IDLE cycle) when tx_done never came
//
// Parameters:
//   CMD          command bytes, CMD[15:8] sent first
//   GAP_CYC      idle cycles between a tx_done and the next tx_start
//   TIMEOUT_CYC  max cycles waiting for tx_done per byte (1 .. 2^20-1)

module voice_cmd_tx #(
    parameter logic [15:0] CMD         = 16'h5131,
    parameter int          GAP_CYC     = 100,
    parameter int          TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_req,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic       send_done,
    output logic       err_timeout
);

`ifdef VOICE_CMD_CRLF_EN
    localparam int IDX_W = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;

    function automatic logic [7:0] cmd_byte(input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = CMD[15:8];
            2'd1:    b = CMD[7:0];
            2'd2:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction
`else
    localparam int IDX_W = 1;
    localparam logic [IDX_W-1:0] LAST_IDX = 1'b1;

    function automatic logic [7:0] cmd_byte(input logic [IDX_W-1:0] idx);
        return idx[0] ? CMD[7:0] : CMD[15:8];
    endfunction
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_GAP,
        S_FINISH
    } state_t;

    localparam logic [19:0] WAIT_LAST = 20'(TIMEOUT_CYC - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [19:0]      wait_q, wait_d;
    logic [31:0]      gap_q, gap_d;
    logic             pend_q, pend_d;
    logic [7:0]       data_q, data_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            gap_q   <= '0;
            pend_q  <= 1'b0;
            data_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        gap_d   = gap_q;
        pend_d  = pend_q;
        data_d  = data_q;
        err_d   = 1'b0;

        // One-deep request memory: a request seen while busy (FINISH
        // included) is remembered; extra ones while already set are lost.
        if (send_req && (state_q != S_IDLE)) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (send_req) begin
                    state_d = S_START;
                    idx_d   = '0;
                end
            end

            S_START: begin
                state_d = S_WAIT_DONE;
                wait_d  = '0;
            end

            S_WAIT_DONE: begin
                // tx_done is tested first so it wins over the timeout.
                if (tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (GAP_CYC == 0) begin
                            state_d = S_START;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end
                    end
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    pend_d  = 1'b0;
                    idx_d   = '0;
                end else begin
                    wait_d = wait_q + 20'd1;
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_START;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end

            S_FINISH: begin
                idx_d = '0;
                // A request arriving in this very cycle restarts too.
                if (pend_q || send_req) begin
                    state_d = S_START;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Load the byte only when entering START so tx_data is held
        // through WAIT_DONE/GAP and keeps its last value in IDLE.
        if (state_d == S_START) begin
            data_d = cmd_byte(idx_d);
        end
    end

    assign tx_data     = data_q;
    assign tx_start    = (state_q == S_START);
    assign busy        = (state_q != S_IDLE);
    assign send_done   = (state_q == S_FINISH);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_voice_cmd_tx.sv
// Bench for voice_cmd_tx: dut_a (GAP_CYC=4, TIMEOUT_CYC=50) and
// dut_b (GAP_CYC=0, TIMEOUT_CYC=50). Inputs change #1 after posedge,
// outputs are checked at negedge.

module tb_voice_cmd_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- DUT A ----------------
    logic       req_a      = 1'b0;
    logic       man_done_a = 1'b0;
    logic       man_mode_a = 1'b1;
    logic       model_en_a = 1'b0;
    logic       mdone_a    = 1'b0;
    int         mcnt_a     = 0;
    logic       done_a;
    logic [7:0] tx_data_a;
    logic       tx_start_a, busy_a, send_done_a, err_a_o;

    assign done_a = man_mode_a ? man_done_a : mdone_a;

    voice_cmd_tx #(.CMD(16'h5131), .GAP_CYC(4), .TIMEOUT_CYC(50)) dut_a (
        .clk(clk), .rst_n(rst_n), .send_req(req_a), .tx_done(done_a),
        .tx_data(tx_data_a), .tx_start(tx_start_a), .busy(busy_a),
        .send_done(send_done_a), .err_timeout(err_a_o)
    );

    // ---------------- DUT B ----------------
    logic       req_b      = 1'b0;
    logic       model_en_b = 1'b0;
    logic       mdone_b    = 1'b0;
    int         mcnt_b     = 0;
    logic [7:0] tx_data_b;
    logic       tx_start_b, busy_b, send_done_b, err_b_o;

    voice_cmd_tx #(.CMD(16'h5131), .GAP_CYC(0), .TIMEOUT_CYC(50)) dut_b (
        .clk(clk), .rst_n(rst_n), .send_req(req_b), .tx_done(mdone_b),
        .tx_data(tx_data_b), .tx_start(tx_start_b), .busy(busy_b),
        .send_done(send_done_b), .err_timeout(err_b_o)
    );

    // UART models: tx_done pulses 10 cycles after the tx_start cycle.
    always @(posedge clk) begin
        mdone_a <= 1'b0;
        if (mcnt_a != 0) begin
            mcnt_a <= mcnt_a - 1;
            if (mcnt_a == 1) mdone_a <= 1'b1;
        end else if (tx_start_a && model_en_a) begin
            mcnt_a <= 9;
        end
    end

    always @(posedge clk) begin
        mdone_b <= 1'b0;
        if (mcnt_b != 0) begin
            mcnt_b <= mcnt_b - 1;
            if (mcnt_b == 1) mdone_b <= 1'b1;
        end else if (tx_start_b && model_en_b) begin
            mcnt_b <= 9;
        end
    end

    // Monitors
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    int st_cyc_a[$];
    int st_cyc_b[$];
    int done_cyc_a[$];
    int done_cyc_b[$];
    int sd_a = 0, sd_b = 0, err_a = 0, err_b = 0, err_cyc_a = 0;

    always @(negedge clk) begin
        if (tx_start_a) begin got_a.push_back(tx_data_a); st_cyc_a.push_back(cyc); end
        if (tx_start_b) begin got_b.push_back(tx_data_b); st_cyc_b.push_back(cyc); end
        if (done_a) done_cyc_a.push_back(cyc);
        if (mdone_b) done_cyc_b.push_back(cyc);
        if (send_done_a) sd_a++;
        if (send_done_b) sd_b++;
        if (err_a_o) begin err_a++; err_cyc_a = cyc; end
        if (err_b_o) err_b++;
    end

    // Scoreboard
    logic [7:0] exp_q[$];

    task automatic load_exp(input int ncmd);
        exp_q.delete();
        repeat (ncmd) begin
            exp_q.push_back(8'h51);
            exp_q.push_back(8'h31);
`ifdef VOICE_CMD_CRLF_EN
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
`endif
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_bytes(input logic sel, input string nm);
        logic [7:0] g[$];
        if (sel) g = got_b; else g = got_a;
        check({nm, " byte count"}, g.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < g.size()) check($sformatf("%s byte%0d", nm, i), g[i], exp_q[i]);
        end
    endtask

    task automatic clear_mon();
        got_a.delete(); got_b.delete();
        st_cyc_a.delete(); st_cyc_b.delete();
        done_cyc_a.delete(); done_cyc_b.delete();
        sd_a = 0; sd_b = 0; err_a = 0; err_b = 0; err_cyc_a = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a();
        req_a = 1'b1; tick(); req_a = 1'b0;
    endtask

    // Bounded wait for busy to drop; an expired budget fails the check.
    task automatic wait_idle(input logic sel, input int budget, input string nm);
        int n = 0;
        while (((sel ? busy_b : busy_a) === 1'b1) && (n < budget)) begin
            tick();
            n++;
        end
        check({nm, " idle reached"}, sel ? busy_b : busy_a, 0);
    endtask

    typedef struct {
        logic       req;
        logic       done;
        logic       start;
        logic [7:0] data;
        logic       busy;
        logic       sd;
        logic       err;
    } vec_t;

    localparam int NV = 29;
    vec_t vec[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Single send on dut_a, tx_done driven by hand 10 cycles after tx_start.
        for (int i = 0; i < NV; i++) vec[i] = '{1'b0, 1'b0, 1'b0, 8'h51, 1'b1, 1'b0, 1'b0};
        vec[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vec[1].start = 1'b1;
        vec[11].done = 1'b1;
        for (int i = 16; i < NV; i++) vec[i].data = 8'h31;
        vec[16].start = 1'b1;   // 5 cycles after tx_done at 11
        vec[26].done  = 1'b1;
`ifndef VOICE_CMD_CRLF_EN
        vec[27].sd   = 1'b1;    // FINISH
        vec[28].busy = 1'b0;    // back in IDLE, data held
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst tx_start_a", tx_start_a, 0);
        check("rst tx_data_a", tx_data_a, 0);
        check("rst busy_a", busy_a, 0);
        check("rst send_done_a", send_done_a, 0);
        check("rst err_a", err_a_o, 0);
        check("rst outputs_b", {tx_start_b, tx_data_b, busy_b, send_done_b, err_b_o}, 0);
        rst_n = 1'b1;
        clear_mon();

        for (int i = 0; i < NV; i++) begin
            tick();
            req_a      = vec[i].req;
            man_done_a = vec[i].done;
            @(negedge clk);
            n_cmp++;
            if ({tx_start_a, tx_data_a, busy_a, send_done_a, err_a_o} !==
                {vec[i].start, vec[i].data, vec[i].busy, vec[i].sd, vec[i].err}) begin
                n_bad++;
                $display("FAIL vec%0d start/data/busy/done/err: got %b/%h/%b/%b/%b expected %b/%h/%b/%b/%b",
                         i, tx_start_a, tx_data_a, busy_a, send_done_a, err_a_o,
                         vec[i].start, vec[i].data, vec[i].busy, vec[i].sd, vec[i].err);
            end
        end
        tick();
        req_a = 1'b0; man_done_a = 1'b0;
        man_mode_a = 1'b0; model_en_a = 1'b1;
        wait_idle(1'b0, 300, "single");
        repeat (5) tick();
        load_exp(1);
        check_bytes(1'b0, "single");
        check("single send_done count", sd_a, 1);
        check("single err count", err_a, 0);

        // GAP_CYC=0 on dut_b: next tx_start right after tx_done.
        clear_mon();
        model_en_b = 1'b1;
        req_b = 1'b1; tick(); req_b = 1'b0;
        wait_idle(1'b1, 300, "gap0");
        repeat (5) tick();
        load_exp(1);
        check_bytes(1'b1, "gap0");
        check("gap0 send_done count", sd_b, 1);
        if (st_cyc_b.size() > 1 && done_cyc_b.size() > 0)
            check("gap0 done->start cycles", st_cyc_b[1] - done_cyc_b[0], 1);
        else
            check("gap0 start/done seen", {st_cyc_b.size() > 1, done_cyc_b.size() > 0}, 2'b11);

        // Pending request plus a dropped third request.
        clear_mon();
        pulse_a();
        repeat (3) tick();
        pulse_a();              // during byte 0 -> pending
        repeat (4) tick();
        pulse_a();              // already pending -> dropped
        wait_idle(1'b0, 600, "pending");
        check("pending send_done before busy fell", sd_a, 2);
        repeat (30) tick();
        load_exp(2);
        check_bytes(1'b0, "pending");
        check("pending send_done count", sd_a, 2);
        check("pending err count", err_a, 0);

        // Timeout: model silent.
        clear_mon();
        model_en_a = 1'b0;
        pulse_a();
        wait_idle(1'b0, 200, "timeout");
        repeat (30) tick();
        check("timeout err count", err_a, 1);
        check("timeout send_done count", sd_a, 0);
        if (st_cyc_a.size() > 0)
            check("timeout cycles after WAIT_DONE entry", err_cyc_a - (st_cyc_a[0] + 1), 50);
        exp_q.delete();
        exp_q.push_back(8'h51);
        check_bytes(1'b0, "timeout");
        check("timeout busy after", busy_a, 0);

        // Reset while in GAP.
        clear_mon();
        model_en_a = 1'b1;
        pulse_a();
        for (int n = 0; n < 40 && done_cyc_a.size() == 0; n++) tick();
        check("rstgap tx_done seen", done_cyc_a.size() > 0, 1);
        repeat (2) tick();
        check("rstgap in gap busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check("rstgap outputs zero", {tx_start_a, tx_data_a, busy_a, send_done_a, err_a_o}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        clear_mon();
        repeat (25) tick();
        check("rstgap no tx_start after release", got_a.size(), 0);
        check("rstgap no send_done", sd_a, 0);
        pulse_a();
        wait_idle(1'b0, 300, "rstgap resend");
        repeat (5) tick();
        load_exp(1);
        check_bytes(1'b0, "rstgap resend");
        check("rstgap resend send_done", sd_a, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
